sram_wbuf: RTL and testbench

- Posted-write buffer between the CPU core's data-side SRAM-like port and the data-side SRAM-like port of the AXI bridge.
- Stores are acknowledged to the core one cycle after acceptance. They drain to the bridge in order, one transaction in flight at a time.
- Loads are forwarded only after every buffered store has completed downstream, so memory ordering holds with no address compare.

---
 rtl/sram_wbuf.sv | 131 +++++++++++++
 tb/tb_sram_wbuf.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wbuf.sv
// Posted-write buffer between the core data-side SRAM port and the AXI bridge.
// Stores are acknowledged early and drained in order; loads wait for an empty buffer.
module sram_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   cpu_req,
    input  logic                   cpu_wr,
    input  logic [1:0]             cpu_size,
    input  logic [3:0]             cpu_wstrb,
    input  logic [AW-1:0]          cpu_addr,
    input  logic [31:0]            cpu_wdata,
    output logic                   cpu_addr_ok,
    output logic                   cpu_data_ok,
    output logic [31:0]            cpu_rdata,
    output logic                   mem_req,
    output logic                   mem_wr,
    output logic [1:0]             mem_size,
    output logic [3:0]             mem_wstrb,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic                   mem_addr_ok,
    input  logic                   mem_data_ok,
    input  logic [31:0]            mem_rdata,
    output logic [$clog2(DEPTH):0] wbuf_count,
    output logic                   wbuf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        W_WAIT,
        R_WAIT
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          wack;
    logic          push, pop, load_fwd;

    logic [AW-1:0] addr_q  [DEPTH];
    logic [1:0]    size_q  [DEPTH];
    logic [3:0]    wstrb_q [DEPTH];
    logic [31:0]   wdata_q [DEPTH];

    // Store acceptance uses the pre-pop count so it never waits on mem_data_ok.
    assign push        = cpu_req & cpu_wr & (count < FULL) & (state != R_WAIT) & ~load_fwd;
    assign cpu_addr_ok = push | (load_fwd & mem_addr_ok);
    assign cpu_data_ok = wack | ((state == R_WAIT) & mem_data_ok);
    assign wbuf_count  = count;
    assign wbuf_empty  = (count == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            wack   <= 1'b0;
        end else begin
            state <= state_nxt;
            wack  <= push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr]  <= cpu_addr;
            size_q[wr_ptr]  <= cpu_size;
            wstrb_q[wr_ptr] <= cpu_wstrb;
            wdata_q[wr_ptr] <= cpu_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        load_fwd  = 1'b0;
        pop       = 1'b0;
        cpu_rdata = '0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    mem_req   = 1'b1;
                    mem_wr    = 1'b1;
                    mem_size  = size_q[rd_ptr];
                    mem_wstrb = wstrb_q[rd_ptr];
                    mem_addr  = addr_q[rd_ptr];
                    mem_wdata = wdata_q[rd_ptr];
                    if (mem_addr_ok) state_nxt = W_WAIT;
                end else if (cpu_req & ~cpu_wr & ~wack) begin
                    load_fwd = 1'b1;
                    mem_req  = 1'b1;
                    mem_size = cpu_size;
                    mem_addr = cpu_addr;
                    if (mem_addr_ok) state_nxt = R_WAIT;
                end
            end
            W_WAIT: begin
                if (mem_data_ok) begin
                    pop       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            R_WAIT: begin
                cpu_rdata = mem_rdata;
                if (mem_data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_wbuf.sv
// Directed bench for sram_wbuf: stores, fill/stall, load ordering, push/pop, reset, loads.
module tb_sram_wbuf;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req, cpu_wr;
    logic [1:0]  cpu_size;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_addr_ok, cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  wbuf_count;
    logic        wbuf_empty;

    int checks = 0;
    int errors = 0;

    sram_wbuf #(.DEPTH(4), .AW(32)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_wstrb(cpu_wstrb),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .wbuf_count(wbuf_count), .wbuf_empty(wbuf_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_size = 2'd2; cpu_wstrb = 4'hF;
        cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_load(input logic [31:0] a);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_wstrb = 4'h0;
        cpu_addr = a; cpu_wdata = '0;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d);
        set_store(a, d);
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b1) begin
            errors++; $display("FAIL push_addr_ok addr=%h got %b exp 1", a, cpu_addr_ok);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    // Waits (bounded) for a write request, checks its address, completes it.
    task automatic drain_one(input logic [31:0] exp_addr);
        int unsigned n;
        n = 0;
        mem_addr_ok = 1'b1;
        #1;
        while (mem_req !== 1'b1 && n < 20) begin
            tick(); #1; n++;
        end
        checks++;
        if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL drain req=%b wr=%b addr=%h exp req=1 wr=1 addr=%h", mem_req, mem_wr, mem_addr, exp_addr);
        end
        tick();
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cpu_req = 0; cpu_wr = 0; cpu_size = 0; cpu_wstrb = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        repeat (3) tick();
        #1;
        checks++;
        if (wbuf_count !== 3'd0 || wbuf_empty !== 1'b1) begin
            errors++; $display("FAIL rst_count got cnt=%0d empty=%b exp 0/1", wbuf_count, wbuf_empty);
        end
        checks++;
        if (mem_req !== 1'b0 || cpu_addr_ok !== 1'b0 || cpu_data_ok !== 1'b0) begin
            errors++; $display("FAIL rst_outputs got req=%b aok=%b dok=%b exp 0/0/0", mem_req, cpu_addr_ok, cpu_data_ok);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_store();
        mem_addr_ok = 1'b1;
        set_store(32'hBFAF_0000, 32'h1234_5678);
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL single_accept got aok=%b req=%b exp 1/0", cpu_addr_ok, mem_req);
        end
        tick();
        cpu_req = 1'b0;
        #1;
        checks++;
        if (cpu_data_ok !== 1'b1 || mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'hBFAF_0000
            || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'hF || mem_size !== 2'd2 || wbuf_count !== 3'd1) begin
            errors++;
            $display("FAIL single_issue got dok=%b req=%b wr=%b addr=%h data=%h strb=%h size=%0d cnt=%0d exp 1/1/1/bfaf0000/12345678/f/2/1",
                     cpu_data_ok, mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb, mem_size, wbuf_count);
        end
        tick();
        #1;
        checks++;
        if (cpu_data_ok !== 1'b0 || mem_req !== 1'b0 || wbuf_count !== 3'd1) begin
            errors++; $display("FAIL single_wwait got dok=%b req=%b cnt=%0d exp 0/0/1", cpu_data_ok, mem_req, wbuf_count);
        end
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (wbuf_count !== 3'd0 || wbuf_empty !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL single_pop got cnt=%0d empty=%b req=%b exp 0/1/0", wbuf_count, wbuf_empty, mem_req);
        end
    endtask

    task automatic test_fill_full();
        mem_addr_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_store(32'h0000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
            #1;
            checks++;
            if (cpu_addr_ok !== (i < 4) || cpu_data_ok !== (i >= 1)) begin
                errors++; $display("FAIL fill_%0d got aok=%b dok=%b exp %b/%b", i, cpu_addr_ok, cpu_data_ok, (i < 4), (i >= 1));
            end
            if (i < 4) tick();
        end
        tick();
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b0 || wbuf_count !== 3'd4 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            errors++; $display("FAIL full_stall got aok=%b cnt=%0d req=%b addr=%h exp 0/4/1/100", cpu_addr_ok, wbuf_count, mem_req, mem_addr);
        end
        mem_addr_ok = 1'b1;
        tick();
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b0) begin
            errors++; $display("FAIL full_pop_cycle got aok=%b exp 0", cpu_addr_ok);
        end
        tick();
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (wbuf_count !== 3'd3 || cpu_addr_ok !== 1'b1 || mem_addr !== 32'h104) begin
            errors++; $display("FAIL full_after_pop got cnt=%0d aok=%b addr=%h exp 3/1/104", wbuf_count, cpu_addr_ok, mem_addr);
        end
        tick();
        cpu_req = 1'b0;
        #1;
        checks++;
        if (wbuf_count !== 3'd4 || cpu_data_ok !== 1'b1) begin
            errors++; $display("FAIL full_refill got cnt=%0d dok=%b exp 4/1", wbuf_count, cpu_data_ok);
        end
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0;
        drain_one(32'h108);
        drain_one(32'h10C);
        drain_one(32'h110);
        #1;
        checks++;
        if (wbuf_count !== 3'd0) begin
            errors++; $display("FAIL full_drained got cnt=%0d exp 0", wbuf_count);
        end
    endtask

    task automatic test_load_after_stores();
        mem_addr_ok = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        push_store(32'h200, 32'h1);
        push_store(32'h204, 32'h2);
        set_load(32'h8000_0100);
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b0) begin
            errors++; $display("FAIL load_blocked_0 got aok=%b exp 0", cpu_addr_ok);
        end
        drain_one(32'h200);
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b0 || wbuf_count !== 3'd1) begin
            errors++; $display("FAIL load_blocked_1 got aok=%b cnt=%0d exp 0/1", cpu_addr_ok, wbuf_count);
        end
        drain_one(32'h204);
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b1 || mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h8000_0100
            || mem_wstrb !== 4'h0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL load_fwd got aok=%b req=%b wr=%b addr=%h strb=%h rdata=%h exp 1/1/0/80000100/0/0",
                     cpu_addr_ok, mem_req, mem_wr, mem_addr, mem_wstrb, cpu_rdata);
        end
        tick();
        cpu_req = 1'b0;
        tick();
        #1;
        checks++;
        if (cpu_data_ok !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL load_wait got dok=%b req=%b exp 0/0", cpu_data_ok, mem_req);
        end
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_data got dok=%b rdata=%h exp 1/deadbeef", cpu_data_ok, cpu_rdata);
        end
        tick();
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (cpu_data_ok !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++; $display("FAIL load_done got dok=%b rdata=%h exp 0/0", cpu_data_ok, cpu_rdata);
        end
    endtask

    task automatic test_push_pop();
        mem_addr_ok = 1'b0;
        push_store(32'h300, 32'h30);
        push_store(32'h304, 32'h31);
        push_store(32'h308, 32'h32);
        drain_one(32'h300);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h304 || wbuf_count !== 3'd2) begin
            errors++; $display("FAIL pp_head got req=%b addr=%h cnt=%0d exp 1/304/2", mem_req, mem_addr, wbuf_count);
        end
        tick();
        set_store(32'h30C, 32'h33);
        mem_data_ok = 1'b1;
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b1 || wbuf_count !== 3'd2) begin
            errors++; $display("FAIL pp_accept got aok=%b cnt=%0d exp 1/2", cpu_addr_ok, wbuf_count);
        end
        mem_addr_ok = 1'b0;
        tick();
        cpu_req = 1'b0;
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (wbuf_count !== 3'd2 || cpu_data_ok !== 1'b1 || mem_addr !== 32'h308) begin
            errors++; $display("FAIL pp_count got cnt=%0d dok=%b addr=%h exp 2/1/308", wbuf_count, cpu_data_ok, mem_addr);
        end
        push_store(32'h310, 32'h34);
        push_store(32'h314, 32'h35);
        #1;
        checks++;
        if (wbuf_count !== 3'd4) begin
            errors++; $display("FAIL pp_full got cnt=%0d exp 4", wbuf_count);
        end
        drain_one(32'h308);
        drain_one(32'h30C);
        drain_one(32'h310);
        drain_one(32'h314);
        #1;
        checks++;
        if (wbuf_empty !== 1'b1) begin
            errors++; $display("FAIL pp_empty got empty=%b exp 1", wbuf_empty);
        end
    endtask

    task automatic test_reset_mid_drain();
        mem_addr_ok = 1'b0;
        push_store(32'h400, 32'h40);
        push_store(32'h404, 32'h41);
        push_store(32'h408, 32'h42);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || wbuf_count !== 3'd3) begin
            errors++; $display("FAIL rmd_wwait got req=%b cnt=%0d exp 0/3", mem_req, wbuf_count);
        end
        resetn = 1'b0;
        tick();
        #1;
        checks++;
        if (wbuf_count !== 3'd0 || wbuf_empty !== 1'b1 || mem_req !== 1'b0 || cpu_data_ok !== 1'b0) begin
            errors++; $display("FAIL rmd_cleared got cnt=%0d empty=%b req=%b dok=%b exp 0/1/0/0", wbuf_count, wbuf_empty, mem_req, cpu_data_ok);
        end
        resetn = 1'b1;
        tick();
        set_load(32'h500);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h500 || cpu_addr_ok !== 1'b0) begin
            errors++; $display("FAIL rmd_idle got req=%b wr=%b addr=%h aok=%b exp 1/0/500/0", mem_req, mem_wr, mem_addr, cpu_addr_ok);
        end
        cpu_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        mem_addr_ok = 1'b1;
        set_load(32'h600);
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h600) begin
            errors++; $display("FAIL b2b_l1 got aok=%b req=%b addr=%h exp 1/1/600", cpu_addr_ok, mem_req, mem_addr);
        end
        tick();
        set_load(32'h604);
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b0 || mem_req !== 1'b0 || cpu_data_ok !== 1'b0) begin
            errors++; $display("FAIL b2b_l2_wait got aok=%b req=%b dok=%b exp 0/0/0", cpu_addr_ok, mem_req, cpu_data_ok);
        end
        mem_data_ok = 1'b1;
        mem_rdata = 32'h1111_1111;
        #1;
        checks++;
        if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h1111_1111 || cpu_addr_ok !== 1'b0) begin
            errors++; $display("FAIL b2b_d1 got dok=%b rdata=%h aok=%b exp 1/11111111/0", cpu_data_ok, cpu_rdata, cpu_addr_ok);
        end
        tick();
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (cpu_addr_ok !== 1'b1 || mem_addr !== 32'h604 || cpu_data_ok !== 1'b0) begin
            errors++; $display("FAIL b2b_l2 got aok=%b addr=%h dok=%b exp 1/604/0", cpu_addr_ok, mem_addr, cpu_data_ok);
        end
        tick();
        cpu_req = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata = 32'h2222_2222;
        #1;
        checks++;
        if (cpu_data_ok !== 1'b1 || cpu_rdata !== 32'h2222_2222) begin
            errors++; $display("FAIL b2b_d2 got dok=%b rdata=%h exp 1/22222222", cpu_data_ok, cpu_rdata);
        end
        tick();
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if (cpu_data_ok !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL b2b_end got dok=%b req=%b exp 0/0", cpu_data_ok, mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill_full();
        test_load_after_stores();
        test_push_pop();
        test_reset_mid_drain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
